check_scoreboard: RTL and testbench

- Streaming result checker for self-checking simulation benches.
- The stimulus side pushes expected values into an internal FIFO. The DUT side presents observed results. Each result is popped against the oldest expected value.
- Compares after width/sign extension, counts checks and mismatches, and latches the first failure.
- Raises a stop request on an error limit, or a finished/pass indication at end of test.

---
 rtl/check_scoreboard.sv | 182 ++++++++++++++++++
 tb/tb_check_scoreboard.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/check_scoreboard.sv
// check_scoreboard: streaming result checker. Expected values queue in a small
// FIFO; each observed result is compared against the oldest expected value
// after extending both to a common width. Tracks check/mismatch counts, keeps
// the first failure, and ends in STOPPED (error limit) or FINISHED (end of test).
module check_scoreboard #(
  parameter int GOT_W   = 1,
  parameter int EXP_W   = 2,
  parameter int SIGNED  = 1,
  parameter int DEPTH   = 4,
  parameter int MAX_ERR = 1,
  localparam int W      = (GOT_W > EXP_W) ? GOT_W : EXP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [EXP_W-1:0] exp_data,
  input  logic             got_valid,
  output logic             got_ready,
  input  logic [GOT_W-1:0] got_data,
  input  logic             end_req,
  output logic [15:0]      chk_count,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx,
  output logic [W-1:0]     first_got,
  output logic [W-1:0]     first_exp,
  output logic             mismatch,
  output logic             stop_req,
  output logic             finished,
  output logic             pass
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {ST_RUN, ST_STOPPED, ST_FINISHED} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             end_pend_q, end_pend_d;
  logic [15:0]      chk_count_q, chk_count_d;
  logic [15:0]      err_count_q, err_count_d;
  logic [15:0]      first_err_idx_q, first_err_idx_d;
  logic [W-1:0]     first_got_q, first_got_d;
  logic [W-1:0]     first_exp_q, first_exp_d;
  logic             mismatch_q, mismatch_d;
  logic             pass_q, pass_d;

  logic [EXP_W-1:0] mem [DEPTH];

  logic             running;
  logic             empty;
  logic             full;
  logic             push;
  logic             hs;
  logic [EXP_W-1:0] head;
  logic [W-1:0]     got_ext;
  logic [W-1:0]     exp_ext;
  logic             is_mis;

  // The extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign running   = (state_q == ST_RUN);
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign exp_ready = running && !full;
  assign got_ready = running && !empty;
  assign push      = exp_valid && exp_ready;
  assign hs        = got_valid && got_ready;
  assign head      = mem[rptr_q[AW-1:0]];

  // Extend both operands to W; case inequality makes X/Z on got a mismatch.
  always_comb begin
    if (SIGNED != 0) begin
      got_ext = W'($signed(got_data));
      exp_ext = W'($signed(head));
    end else begin
      got_ext = W'(got_data);
      exp_ext = W'(head);
    end
    is_mis = (got_ext !== exp_ext);
  end

  // Next-state logic for pointers, counters, first-failure capture and FSM.
  always_comb begin
    state_d         = state_q;
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    end_pend_d      = end_pend_q;
    chk_count_d     = chk_count_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    first_got_d     = first_got_q;
    first_exp_d     = first_exp_q;
    mismatch_d      = 1'b0;

    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end

    if (hs) begin
      rptr_d = rptr_q + PTR_ONE;
      if (chk_count_q != 16'hFFFF) begin
        chk_count_d = chk_count_q + 16'd1;
      end
      if (is_mis) begin
        mismatch_d = 1'b1;
        if (err_count_q == 16'd0) begin
          first_err_idx_d = chk_count_q;
          first_got_d     = got_ext;
          first_exp_d     = exp_ext;
        end
        if (err_count_q != 16'hFFFF) begin
          err_count_d = err_count_q + 16'd1;
        end
      end
    end

    if (running && end_req) begin
      end_pend_d = 1'b1;
    end

    // Stop on the error limit takes priority over finishing.
    if (running) begin
      if ((MAX_ERR != 0) && hs && is_mis && (err_count_d == 16'(MAX_ERR))) begin
        state_d = ST_STOPPED;
      end else if (end_pend_q && empty && !hs) begin
        state_d = ST_FINISHED;
      end
    end

    pass_d = (state_d == ST_FINISHED) && (err_count_d == 16'd0);
  end

  // Control and status registers, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      wptr_q          <= '0;
      rptr_q          <= '0;
      end_pend_q      <= 1'b0;
      chk_count_q     <= '0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      first_got_q     <= '0;
      first_exp_q     <= '0;
      mismatch_q      <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      end_pend_q      <= end_pend_d;
      chk_count_q     <= chk_count_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      first_got_q     <= first_got_d;
      first_exp_q     <= first_exp_d;
      mismatch_q      <= mismatch_d;
      pass_q          <= pass_d;
    end
  end

  // Expected-value storage; contents need no reset since pointers gate access.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q[AW-1:0]] <= exp_data;
    end
  end

  assign chk_count     = chk_count_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign first_got     = first_got_q;
  assign first_exp     = first_exp_q;
  assign mismatch      = mismatch_q;
  assign stop_req      = (state_q == ST_STOPPED);
  assign finished      = (state_q == ST_FINISHED);
  assign pass          = pass_q;

endmodule

// File: tb/tb_check_scoreboard.sv
// Bench for check_scoreboard: two instances (defaults, and SIGNED=0/MAX_ERR=0)
// share stimulus; sel routes valids to one of them. Expected mismatch bits are
// queued at stimulus time and compared by a monitor after each handshake.
module tb_check_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        exp_valid = 1'b0;
  logic [1:0]  exp_data = 2'b00;
  logic        got_valid = 1'b0;
  logic [0:0]  got_data = 1'b0;
  logic        end_req = 1'b0;

  logic        a_exp_ready, a_got_ready, a_mis, a_stop, a_fin, a_pass;
  logic [15:0] a_chk, a_err, a_idx;
  logic [1:0]  a_fgot, a_fexp;
  logic        b_exp_ready, b_got_ready, b_mis, b_stop, b_fin, b_pass;
  logic [15:0] b_chk, b_err, b_idx;
  logic [1:0]  b_fgot, b_fexp;

  logic        m_exp_ready, m_got_ready, m_mis, m_stop, m_fin, m_pass;
  logic [15:0] m_chk, m_err, m_idx;
  logic [1:0]  m_fgot, m_fexp;

  int          vectors = 0;
  int          miscompares = 0;
  logic        sb_q[$];

  always #5 clk = ~clk;

  check_scoreboard u_dut_a (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid && !sel), .exp_ready(a_exp_ready), .exp_data(exp_data),
    .got_valid(got_valid && !sel), .got_ready(a_got_ready), .got_data(got_data),
    .end_req(end_req && !sel),
    .chk_count(a_chk), .err_count(a_err), .first_err_idx(a_idx),
    .first_got(a_fgot), .first_exp(a_fexp), .mismatch(a_mis),
    .stop_req(a_stop), .finished(a_fin), .pass(a_pass)
  );

  check_scoreboard #(.SIGNED(0), .MAX_ERR(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid && sel), .exp_ready(b_exp_ready), .exp_data(exp_data),
    .got_valid(got_valid && sel), .got_ready(b_got_ready), .got_data(got_data),
    .end_req(end_req && sel),
    .chk_count(b_chk), .err_count(b_err), .first_err_idx(b_idx),
    .first_got(b_fgot), .first_exp(b_fexp), .mismatch(b_mis),
    .stop_req(b_stop), .finished(b_fin), .pass(b_pass)
  );

  assign m_exp_ready = sel ? b_exp_ready : a_exp_ready;
  assign m_got_ready = sel ? b_got_ready : a_got_ready;
  assign m_mis       = sel ? b_mis  : a_mis;
  assign m_stop      = sel ? b_stop : a_stop;
  assign m_fin       = sel ? b_fin  : a_fin;
  assign m_pass      = sel ? b_pass : a_pass;
  assign m_chk       = sel ? b_chk  : a_chk;
  assign m_err       = sel ? b_err  : a_err;
  assign m_idx       = sel ? b_idx  : a_idx;
  assign m_fgot      = sel ? b_fgot : a_fgot;
  assign m_fexp      = sel ? b_fexp : a_fexp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: a handshake seen at one negedge is checked at the next negedge.
  initial begin
    logic hs_prev;
    logic e;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (hs_prev) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_handshake: got handshake expected none");
        end else begin
          e = sb_q.pop_front();
          vectors++;
          $display("compare %0d: mismatch=%0b expected %0b", vectors, m_mis, e);
          if (m_mis !== e) begin
            miscompares++;
            $display("FAIL mismatch_pulse: got %0b expected %0b", m_mis, e);
          end
        end
      end else if (m_mis !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_mismatch: got %0b expected 0", m_mis);
      end
      hs_prev = got_valid && m_got_ready && !rst;
    end
  end

  task automatic reset_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push(input logic [1:0] v);
    int n;
    n = 0;
    exp_valid = 1'b1;
    exp_data  = v;
    @(negedge clk);
    while (!m_exp_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", m_exp_ready, 1);
    @(posedge clk);
    #1 exp_valid = 1'b0;
  endtask

  task automatic give(input logic v, input logic exp_mis);
    int n;
    n = 0;
    sb_q.push_back(exp_mis);
    got_valid = 1'b1;
    got_data  = v;
    @(negedge clk);
    while (!m_got_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("got_ready", m_got_ready, 1);
    @(posedge clk);
    #1 got_valid = 1'b0;
  endtask

  task automatic pulse_end();
    end_req = 1'b1;
    @(posedge clk);
    #1 end_req = 1'b0;
  endtask

  task automatic wait_fin();
    int n;
    n = 0;
    while (!m_fin && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("finished", m_fin, 1);
  endtask

  initial begin
    logic [1:0] v4 [5];
    v4[0] = 2'b00; v4[1] = 2'b01; v4[2] = 2'b11; v4[3] = 2'b01; v4[4] = 2'b10;

    // 1: signed match, then clean finish
    sel = 1'b0;
    reset_all();
    @(negedge clk);
    chk("rst_chk", m_chk, 0);
    chk("rst_err", m_err, 0);
    chk("rst_stop", m_stop, 0);
    chk("rst_fin", m_fin, 0);
    chk("rst_pass", m_pass, 0);
    chk("rst_exp_ready", m_exp_ready, 1);
    chk("rst_got_ready", m_got_ready, 0);
    @(posedge clk); #1;
    push(2'b11);
    give(1'b1, 1'b0);
    @(negedge clk);
    chk("t1_chk", m_chk, 1);
    chk("t1_err", m_err, 0);
    @(posedge clk); #1;
    pulse_end();
    wait_fin();
    chk("t1_pass", m_pass, 1);

    // 2: signed mismatch hits MAX_ERR=1
    @(posedge clk); #1;
    reset_all();
    push(2'b10);
    give(1'b1, 1'b1);
    @(negedge clk);
    chk("t2_err", m_err, 1);
    chk("t2_fgot", m_fgot, 2'b11);
    chk("t2_fexp", m_fexp, 2'b10);
    chk("t2_idx", m_idx, 0);
    chk("t2_stop", m_stop, 1);
    chk("t2_exp_ready", m_exp_ready, 0);
    chk("t2_got_ready", m_got_ready, 0);
    @(negedge clk);
    chk("t2_mis_one_cycle", m_mis, 0);

    // 3: unsigned, no stop limit, finish with pass=0
    @(posedge clk); #1;
    sel = 1'b1;
    reset_all();
    push(2'b01);
    give(1'b1, 1'b0);
    push(2'b11);
    give(1'b1, 1'b1);
    @(negedge clk);
    chk("t3_err", m_err, 1);
    chk("t3_idx", m_idx, 1);
    chk("t3_fgot", m_fgot, 2'b01);
    chk("t3_fexp", m_fexp, 2'b11);
    chk("t3_stop", m_stop, 0);
    @(posedge clk); #1;
    pulse_end();
    wait_fin();
    chk("t3_pass", m_pass, 0);

    // 4: fill, full back-pressure, pop frees a slot, wrapped ordering
    @(posedge clk); #1;
    reset_all();
    exp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_data = v4[i];
      @(negedge clk);
      chk("t4_fill_ready", m_exp_ready, 1);
      @(posedge clk); #1;
    end
    exp_data = v4[4];
    @(negedge clk);
    chk("t4_full", m_exp_ready, 0);
    @(posedge clk); #1;
    sb_q.push_back(1'b0);
    got_valid = 1'b1;
    got_data  = 1'b0;
    @(negedge clk);
    chk("t4_full_on_pop", m_exp_ready, 0);
    chk("t4_pop_ready", m_got_ready, 1);
    @(posedge clk); #1;
    got_valid = 1'b0;
    @(negedge clk);
    chk("t4_ready_after_pop", m_exp_ready, 1);
    @(posedge clk); #1;
    exp_valid = 1'b0;
    give(1'b1, 1'b0);
    give(1'b1, 1'b1);
    give(1'b1, 1'b0);
    give(1'b0, 1'b1);
    @(negedge clk);
    chk("t4_chk", m_chk, 5);
    chk("t4_err", m_err, 2);
    chk("t4_idx", m_idx, 2);

    // 5: no bypass when empty; finish waits for queued entries
    @(posedge clk); #1;
    sel = 1'b0;
    reset_all();
    sb_q.push_back(1'b0);
    exp_valid = 1'b1;
    exp_data  = 2'b11;
    got_valid = 1'b1;
    got_data  = 1'b1;
    @(negedge clk);
    chk("t5_no_bypass", m_got_ready, 0);
    @(posedge clk); #1;
    exp_valid = 1'b0;
    @(negedge clk);
    chk("t5_got_ready_next", m_got_ready, 1);
    @(posedge clk); #1;
    got_valid = 1'b0;
    push(2'b00);
    push(2'b11);
    pulse_end();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_not_fin_queued", m_fin, 0);
    @(posedge clk); #1;
    give(1'b0, 1'b0);
    @(negedge clk);
    chk("t5_not_fin_one_left", m_fin, 0);
    @(posedge clk); #1;
    give(1'b1, 1'b0);
    wait_fin();
    chk("t5_chk", m_chk, 3);
    chk("t5_pass", m_pass, 1);

    // 6: reset mid-stream flushes everything
    @(posedge clk); #1;
    sel = 1'b1;
    reset_all();
    push(2'b11);
    give(1'b0, 1'b1);
    push(2'b00);
    push(2'b01);
    push(2'b11);
    @(negedge clk);
    chk("t6_err_before", m_err, 1);
    chk("t6_got_ready_before", m_got_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_chk", m_chk, 0);
    chk("t6_err", m_err, 0);
    chk("t6_idx", m_idx, 0);
    chk("t6_fgot", m_fgot, 0);
    chk("t6_fexp", m_fexp, 0);
    chk("t6_empty", m_got_ready, 0);
    chk("t6_exp_ready", m_exp_ready, 1);
    chk("t6_stop", m_stop, 0);
    chk("t6_fin", m_fin, 0);
    chk("t6_pass", m_pass, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
